// File: rtl/axi_dram_responder_pkg.sv
// Shared AXI4 packet types, response codes and sizing helpers for the DRAM responder.
package axi_dram_responder_pkg;

    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_DATA_WIDTH = 64;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_LEN_WIDTH  = 8;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic                      valid;
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [AXI_LEN_WIDTH-1:0]  len;
    } ADDRESS_READ_PACKET;

    typedef struct packed {
        logic                      valid;
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [AXI_LEN_WIDTH-1:0]  len;
    } ADDRESS_WRITE_PACKET;

    typedef struct packed {
        logic                      valid;
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
    } READ_DATA_PACKET;

    typedef struct packed {
        logic                      valid;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic                      last;
    } WRITE_DATA_PACKET;

    typedef struct packed {
        logic                      valid;
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [1:0]                resp;
    } WRITE_RESPONSE_PACKET;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_dram_responder_if.sv
// AXI4 five-channel bundle between the L2 master and the DRAM responder.
interface axi_dram_responder_if;
    import axi_dram_responder_pkg::*;

    ADDRESS_READ_PACKET   ar_packet;
    logic                 ar_ready;
    READ_DATA_PACKET      r_packet;
    logic                 r_ready;
    ADDRESS_WRITE_PACKET  aw_packet;
    logic                 aw_ready;
    WRITE_DATA_PACKET     w_packet;
    logic                 w_ready;
    WRITE_RESPONSE_PACKET b_packet;
    logic                 b_valid;

    modport slave (
        input  ar_packet, r_ready, aw_packet, w_packet, b_valid,
        output ar_ready, r_packet, aw_ready, w_ready, b_packet
    );

    modport master (
        output ar_packet, r_ready, aw_packet, w_packet, b_valid,
        input  ar_ready, r_packet, aw_ready, w_ready, b_packet
    );

endinterface

// File: rtl/axi_dram_responder_memDP.sv
// Backing store: one write port, READ_PORTS registered read ports with read enable.
// A read port only updates its output when enabled, so a stalled consumer sees stable data.
module memDP #(
    parameter  int WIDTH      = 64,
    parameter  int DEPTH      = 4096,
    parameter  int READ_PORTS = 1,
    parameter  bit BYPASS_EN  = 1'b0,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                                  clock,
    input  logic [READ_PORTS-1:0]                 re,
    input  logic [READ_PORTS-1:0][ADDR_W-1:0]     raddr,
    output logic [READ_PORTS-1:0][WIDTH-1:0]      rdata,
    input  logic                                  we,
    input  logic [ADDR_W-1:0]                     waddr,
    input  logic [WIDTH-1:0]                      wdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; storage is intentionally not reset
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [WIDTH-1:0] rdata_q;
        if (BYPASS_EN) begin : g_byp
            // Registered read, forwarding a same-cycle write to the same word
            always_ff @(posedge clock) begin
                if (re[p]) rdata_q <= (we && waddr == raddr[p]) ? wdata : mem[raddr[p]];
            end
        end else begin : g_nobyp
            // Registered read; a same-cycle write is seen one cycle later
            always_ff @(posedge clock) begin
                if (re[p]) rdata_q <= mem[raddr[p]];
            end
        end
        assign rdata[p] = rdata_q;
    end

endmodule

// File: rtl/axi_dram_responder.sv
// AXI4 slave DRAM model: fixed-latency read bursts and write bursts with delayed B response.
// Read and write FSMs are fully independent; both share one dual-port backing store.
module axi_dram_responder
    import axi_dram_responder_pkg::*;
#(
    parameter int DATA_WIDTH    = AXI_DATA_WIDTH,
    parameter int MEM_WORDS     = 4096,
    parameter int READ_LATENCY  = 20,
    parameter int WRITE_LATENCY = 4,
    parameter int ID_WIDTH      = AXI_ID_WIDTH
) (
    input logic                 clock,
    input logic                 reset,
    axi_dram_responder_if.slave bus
);

    localparam int IW  = $clog2(MEM_WORDS);
    localparam int BSH = $clog2(DATA_WIDTH / 8);
    localparam int CW  = $clog2(max_int(READ_LATENCY, WRITE_LATENCY)) + 1;
    localparam int EW  = AXI_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_LAT, W_RESP} w_state_t;

    // ---------------- read channel ----------------
    r_state_t            r_state, r_next;
    logic [ID_WIDTH-1:0] r_id;
    logic [IW-1:0]       r_idx;
    logic [7:0]          r_len, r_beat;
    logic                r_oor;
    logic [CW-1:0]       r_cnt;

    logic [AXI_ADDR_WIDTH-1:0] ar_idx_full;
    logic [EW-1:0]             ar_end;
    logic                      ar_oor;

    logic                  rd_en;
    logic [IW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ar_rdy;
    READ_DATA_PACKET       r_pkt;

    assign ar_idx_full = bus.ar_packet.addr >> BSH;
    assign ar_end      = {1'b0, ar_idx_full} + EW'(bus.ar_packet.len);
    assign ar_oor      = ar_end >= EW'(MEM_WORDS);

    // Read state register
    always_ff @(posedge clock) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // Read next-state: latency wait, then one beat per accepted handshake
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (bus.ar_packet.valid)                r_next = R_WAIT;
            R_WAIT:  if (r_cnt == CW'(1))                    r_next = R_BURST;
            R_BURST: if (bus.r_ready && r_beat == r_len)     r_next = R_IDLE;
            default:                                         r_next = R_IDLE;
        endcase
    end

    // Read datapath: latch the request, count latency and beats
    always_ff @(posedge clock) begin
        if (reset) begin
            r_id   <= '0;
            r_idx  <= '0;
            r_len  <= '0;
            r_oor  <= 1'b0;
            r_cnt  <= '0;
            r_beat <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (bus.ar_packet.valid) begin
                    r_id   <= bus.ar_packet.id;
                    r_idx  <= ar_idx_full[IW-1:0];
                    r_len  <= bus.ar_packet.len;
                    r_oor  <= ar_oor;
                    r_cnt  <= CW'(READ_LATENCY - 1);
                    r_beat <= '0;
                end
                R_WAIT:  r_cnt <= r_cnt - CW'(1);
                R_BURST: if (bus.r_ready) r_beat <= r_beat + 8'd1;
                default: ;
            endcase
        end
    end

    // Read outputs; the store is read one cycle ahead of each beat and held while stalled
    always_comb begin
        r_pkt   = '0;
        ar_rdy  = 1'b0;
        rd_en   = (r_state == R_WAIT && r_cnt == CW'(1)) ||
                  (r_state == R_BURST && bus.r_ready && r_beat != r_len);
        rd_addr = r_idx + IW'(r_state == R_BURST ? r_beat + 8'd1 : 8'd0);
        if (!reset) begin
            ar_rdy = (r_state == R_IDLE);
            if (r_state == R_BURST) begin
                r_pkt.valid = 1'b1;
                r_pkt.id    = r_id;
                r_pkt.data  = r_oor ? '0 : rd_data;
                r_pkt.resp  = r_oor ? AXI_RESP_DECERR : AXI_RESP_OKAY;
                r_pkt.last  = (r_beat == r_len);
            end
        end
    end

    assign bus.ar_ready = ar_rdy;
    assign bus.r_packet = r_pkt;

    // ---------------- write channel ----------------
    w_state_t            w_state, w_next;
    logic [ID_WIDTH-1:0] w_id;
    logic [IW-1:0]       w_idx;
    logic [7:0]          w_len, w_beat;
    logic                w_oor, w_err;
    logic [CW-1:0]       w_cnt;

    logic [AXI_ADDR_WIDTH-1:0] aw_idx_full;
    logic [EW-1:0]             aw_end;
    logic                      aw_oor;
    logic                      w_last_beat;

    logic                  wr_en;
    logic [IW-1:0]         wr_addr;
    logic                  aw_rdy, w_rdy;
    WRITE_RESPONSE_PACKET  b_pkt;

    assign aw_idx_full = bus.aw_packet.addr >> BSH;
    assign aw_end      = {1'b0, aw_idx_full} + EW'(bus.aw_packet.len);
    assign aw_oor      = aw_end >= EW'(MEM_WORDS);
    assign w_last_beat = (w_beat == w_len);

    // Write state register
    always_ff @(posedge clock) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    // Write next-state: the burst length, not w.last, ends the data phase
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if (bus.aw_packet.valid) w_next = W_DATA;
            W_DATA: if (bus.w_packet.valid && w_last_beat)
                        w_next = (WRITE_LATENCY > 1) ? W_LAT : W_RESP;
            W_LAT:  if (w_cnt == CW'(1))     w_next = W_RESP;
            W_RESP: if (bus.b_valid)         w_next = W_IDLE;
            default:                         w_next = W_IDLE;
        endcase
    end

    // Write datapath: latch request, count beats, flag misplaced/missing last
    always_ff @(posedge clock) begin
        if (reset) begin
            w_id   <= '0;
            w_idx  <= '0;
            w_len  <= '0;
            w_oor  <= 1'b0;
            w_err  <= 1'b0;
            w_beat <= '0;
            w_cnt  <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (bus.aw_packet.valid) begin
                    w_id   <= bus.aw_packet.id;
                    w_idx  <= aw_idx_full[IW-1:0];
                    w_len  <= bus.aw_packet.len;
                    w_oor  <= aw_oor;
                    w_err  <= 1'b0;
                    w_beat <= '0;
                end
                W_DATA: if (bus.w_packet.valid) begin
                    w_beat <= w_beat + 8'd1;
                    w_cnt  <= CW'(WRITE_LATENCY - 1);
                    if (bus.w_packet.last != w_last_beat) w_err <= 1'b1;
                end
                W_LAT:   w_cnt <= w_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    // Write outputs; out-of-range beats are accepted but never reach the store
    always_comb begin
        aw_rdy  = 1'b0;
        w_rdy   = 1'b0;
        b_pkt   = '0;
        wr_en   = !reset && w_state == W_DATA && bus.w_packet.valid && !w_oor;
        wr_addr = w_idx + IW'(w_beat);
        if (!reset) begin
            aw_rdy = (w_state == W_IDLE);
            w_rdy  = (w_state == W_DATA);
            if (w_state == W_RESP) begin
                b_pkt.valid = 1'b1;
                b_pkt.id    = w_id;
                b_pkt.resp  = w_oor ? AXI_RESP_DECERR :
                              w_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
        end
    end

    assign bus.aw_ready = aw_rdy;
    assign bus.w_ready  = w_rdy;
    assign bus.b_packet = b_pkt;

    memDP #(
        .WIDTH      (DATA_WIDTH),
        .DEPTH      (MEM_WORDS),
        .READ_PORTS (1),
        .BYPASS_EN  (1'b0)
    ) u_store (
        .clock (clock),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (bus.w_packet.data)
    );

endmodule

// File: tb/tb_axi_dram_responder.sv
// Scoreboard bench for axi_dram_responder: drivers push expected R/B traffic, monitors compare.
module tb_axi_dram_responder;
    import axi_dram_responder_pkg::*;

    localparam int MEM_WORDS = 4096;
    localparam int RL        = 20;
    localparam int WL        = 4;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        int          at;
    } r_exp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
        int         at;
    } b_exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rmode = 0;
    bit   b_hold = 1'b0;
    bit   r_seen = 1'b0;
    bit   b_seen = 1'b0;

    r_exp_t      rq[$];
    b_exp_t      bq[$];
    logic [63:0] model [MEM_WORDS];

    axi_dram_responder_if bus();

    axi_dram_responder #(
        .DATA_WIDTH    (64),
        .MEM_WORDS     (MEM_WORDS),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL),
        .ID_WIDTH      (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign bus.b_valid = !b_hold;

    always @(posedge clock) begin
        #1;
        case (rmode)
            0:       bus.r_ready = 1'b1;
            1:       bus.r_ready = ((cyc % 3) == 0);
            default: bus.r_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // R monitor: compare every presented beat; a stalled beat is compared again each cycle
    always @(negedge clock) begin
        if (!reset && bus.r_packet.valid) begin
            if (rq.size() == 0) begin
                fail_now("r_unexpected_beat");
            end else begin
                chk("r_data", bus.r_packet.data, rq[0].data);
                chk("r_id", 64'(bus.r_packet.id), 64'(rq[0].id));
                chk("r_resp", 64'(bus.r_packet.resp), 64'(rq[0].resp));
                chk("r_last", 64'(bus.r_packet.last), 64'(rq[0].last));
                if (!r_seen && rq[0].at >= 0) chk("r_latency", 64'(cyc), 64'(rq[0].at));
                r_seen = 1'b1;
                if (bus.r_ready) begin
                    void'(rq.pop_front());
                    r_seen = 1'b0;
                end
            end
        end
    end

    // B monitor
    always @(negedge clock) begin
        if (!reset && bus.b_packet.valid) begin
            if (bq.size() == 0) begin
                fail_now("b_unexpected");
            end else begin
                chk("b_id", 64'(bus.b_packet.id), 64'(bq[0].id));
                chk("b_resp", 64'(bus.b_packet.resp), 64'(bq[0].resp));
                if (!b_seen) chk("b_latency", 64'(cyc), 64'(bq[0].at));
                b_seen = 1'b1;
                if (bus.b_valid) begin
                    void'(bq.pop_front());
                    b_seen = 1'b0;
                end
            end
        end
    end

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len, output int hs);
        int idx;
        bit oor;
        r_exp_t e;
        hs = -1;
        bus.ar_packet.valid = 1'b1;
        bus.ar_packet.id    = id;
        bus.ar_packet.addr  = addr;
        bus.ar_packet.len   = 8'(len);
        for (int n = 0; n < 200 && hs < 0; n++) begin
            @(negedge clock);
            if (bus.ar_ready) hs = cyc;
        end
        if (hs < 0) begin
            fail_now("ar_handshake_timeout");
        end else begin
            idx = int'(addr >> 3);
            oor = (idx + len) >= MEM_WORDS;
            for (int k = 0; k <= len; k++) begin
                e.id   = id;
                e.data = oor ? 64'h0 : model[idx + k];
                e.resp = oor ? AXI_RESP_DECERR : AXI_RESP_OKAY;
                e.last = (k == len);
                e.at   = (k == 0) ? hs + RL : -1;
                rq.push_back(e);
            end
        end
        @(posedge clock);
        #1;
        bus.ar_packet = '0;
    endtask

    // lastpos: beat carrying w.last (-1 = none); fixed: data 0xA0+k instead of random
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int lastpos, input bit fixed, output int hs);
        int idx;
        int hsw;
        bit oor;
        bit err;
        bit got;
        logic [63:0] d;
        b_exp_t e;
        hs  = -1;
        hsw = -1;
        err = 1'b0;
        idx = int'(addr >> 3);
        oor = (idx + len) >= MEM_WORDS;
        d   = fixed ? 64'hA0 : {$urandom, $urandom};
        bus.aw_packet.valid = 1'b1;
        bus.aw_packet.id    = id;
        bus.aw_packet.addr  = addr;
        bus.aw_packet.len   = 8'(len);
        bus.w_packet.valid  = 1'b1;
        bus.w_packet.data   = d;
        bus.w_packet.last   = (lastpos == 0);
        for (int n = 0; n < 200 && hs < 0; n++) begin
            @(negedge clock);
            if (bus.aw_ready) begin
                hs = cyc;
                chk("w_ready_before_aw", 64'(bus.w_ready), 64'h0);
            end
        end
        @(posedge clock);
        #1;
        bus.aw_packet = '0;
        if (hs < 0) begin
            fail_now("aw_handshake_timeout");
            bus.w_packet = '0;
            return;
        end
        for (int k = 0; k <= len; k++) begin
            d = fixed ? 64'(32'hA0 + k) : {$urandom, $urandom};
            bus.w_packet.valid = 1'b1;
            bus.w_packet.data  = d;
            bus.w_packet.last  = (k == lastpos);
            got = 1'b0;
            for (int n = 0; n < 200 && !got; n++) begin
                @(negedge clock);
                got = bus.w_ready;
            end
            if (!got) begin
                fail_now("w_handshake_timeout");
                bus.w_packet = '0;
                return;
            end
            if ((k == lastpos) != (k == len)) err = 1'b1;
            if (!oor) model[idx + k] = d;
            if (k == len) hsw = cyc;
            @(posedge clock);
            #1;
        end
        bus.w_packet = '0;
        e.id   = id;
        e.resp = oor ? AXI_RESP_DECERR : (err ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
        e.at   = hsw + WL;
        bq.push_back(e);
    endtask

    task automatic drain();
        for (int n = 0; n < 3000 && (rq.size() != 0 || bq.size() != 0); n++) @(negedge clock);
        if (rq.size() != 0 || bq.size() != 0) begin
            fail_now("drain_timeout");
            rq.delete();
            bq.delete();
        end
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ar_ready"}, 64'(bus.ar_ready), 64'h0);
        chk({tag, "_aw_ready"}, 64'(bus.aw_ready), 64'h0);
        chk({tag, "_w_ready"}, 64'(bus.w_ready), 64'h0);
        chk({tag, "_r_nonzero"}, 64'(bus.r_packet != '0), 64'h0);
        chk({tag, "_b_nonzero"}, 64'(bus.b_packet != '0), 64'h0);
    endtask

    initial begin
        int hr, hw, idx, len;
        bit got;
        bus.ar_packet = '0;
        bus.aw_packet = '0;
        bus.w_packet  = '0;
        for (int i = 0; i < MEM_WORDS; i++) model[i] = 64'h0;

        // reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_all_zero("por");
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("idle_ar_ready", 64'(bus.ar_ready), 64'h1);
        chk("idle_aw_ready", 64'(bus.aw_ready), 64'h1);
        @(posedge clock);
        #1;

        // write then read back
        do_write(4'd3, 32'h40, 3, 3, 1'b1, hw);
        drain();
        do_read(4'd5, 32'h40, 3, hr);
        drain();

        // read backpressure
        do_write(4'd1, 32'(100 << 3), 7, 7, 1'b0, hw);
        drain();
        rmode = 1;
        do_read(4'd2, 32'(100 << 3), 7, hr);
        drain();
        rmode = 0;

        // concurrent AR and AW to different words
        do_write(4'd4, 32'(200 << 3), 3, 3, 1'b0, hw);
        drain();
        fork
            do_read(4'd8, 32'(200 << 3), 3, hr);
            do_write(4'd9, 32'(300 << 3), 2, 2, 1'b0, hw);
        join
        chk("concurrent_accept_cycle", 64'(hr), 64'(hw));
        drain();

        // error responses
        do_write(4'd6, 32'h800, 1, 0, 1'b0, hw);
        drain();
        do_read(4'd7, 32'((MEM_WORDS - 1) << 3), 1, hr);
        drain();
        do_write(4'd10, 32'((MEM_WORDS - 1) << 3), 2, 2, 1'b0, hw);
        drain();

        // B stall
        b_hold = 1'b1;
        do_write(4'd9, 32'(500 << 3), 1, 1, 1'b0, hw);
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clock);
            got = bus.b_packet.valid;
        end
        if (!got) fail_now("b_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            chk("bstall_valid", 64'(bus.b_packet.valid), 64'h1);
            chk("bstall_id", 64'(bus.b_packet.id), 64'h9);
            chk("bstall_aw_ready", 64'(bus.aw_ready), 64'h0);
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        b_hold = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("bdone_aw_ready", 64'(bus.aw_ready), 64'h1);
        drain();

        // reset mid read burst
        do_write(4'd1, 32'(400 << 3), 7, 7, 1'b0, hw);
        drain();
        rmode = 1;
        do_read(4'd2, 32'(400 << 3), 7, hr);
        repeat (RL + 2) @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk_all_zero("midrst");
            @(posedge clock);
        end
        #1;
        reset  = 1'b0;
        rmode  = 0;
        rq.delete();
        r_seen = 1'b0;
        @(negedge clock);
        chk("postrst_ar_ready", 64'(bus.ar_ready), 64'h1);
        chk("postrst_r_valid", 64'(bus.r_packet.valid), 64'h0);
        @(posedge clock);
        #1;

        // randomized write/read pairs
        for (int it = 0; it < 8; it++) begin
            idx = $urandom_range(0, MEM_WORDS - 9);
            len = $urandom_range(0, 7);
            do_write(4'($urandom), 32'(idx << 3) | 32'($urandom_range(0, 7)), len, len, 1'b0, hw);
            drain();
            rmode = $urandom_range(0, 2);
            do_read(4'($urandom), 32'(idx << 3), len, hr);
            drain();
            rmode = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
